// File: rtl/refresh_arbiter.sv
// -----------------------------------------------------------------------------
// refresh_arbiter
//
// Shares the display digit-load path (4-bit digit address plus SL latch strobe)
// between two update sources: source 0 is the counter/prescaler overflow and
// source 1 is the RTC overflow. Each request pulse is captured as a pending
// flag. One source at a time is granted a full burst of NDIG digit loads. Each
// digit holds its address for HOLD cycles and then strobes SL for one cycle.
//
// Parameters:
//   NDIG    digits per burst (1..16)
//   HOLD    cycles the address is held stable before each SL strobe (>=1)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   req[1:0] in   request pulses (bit 0 = ovf, bit 1 = ovf_RTC)
//   gnt[1:0] out  one-hot grant, high for the whole burst of its owner
//   busy     out  high while a burst is in progress
//   addr[3:0]out  binary digit index 0..NDIG-1
//   SL       out  one-cycle latch strobe per digit
//   done     out  one-cycle pulse after the last SL of a burst
//   overrun  out  sticky per source: request while already pending
//
// Configuration macro:
//   REFRESH_ARB_FIXED_PRIO_EN  defined   -> a tie always goes to source 1
//                              undefined -> round-robin tie-break
// -----------------------------------------------------------------------------
module refresh_arbiter #(
  parameter int NDIG = 10,
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [3:0] addr,
  output logic       SL,
  output logic       done,
  output logic [1:0] overrun
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [3:0]    ADDR_LAST = 4'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [1:0]    pend, pend_n;
  logic [1:0]    clr;
  logic          ptr, ptr_n;
  logic          win1;
  logic [1:0]    gnt_n;
  logic          busy_n;
  logic [3:0]    addr_n;
  logic          sl_n;
  logic          done_n;
  logic [1:0]    overrun_n;

  // State register plus registered copies of every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pend     <= 2'b00;
      ptr      <= 1'b0;
      gnt      <= 2'b00;
      busy     <= 1'b0;
      addr     <= 4'd0;
      SL       <= 1'b0;
      done     <= 1'b0;
      overrun  <= 2'b00;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      pend     <= pend_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
      addr     <= addr_n;
      SL       <= sl_n;
      done     <= done_n;
      overrun  <= overrun_n;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead so
  // that the registered values line up with the state they describe.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    ptr_n   = ptr;
    gnt_n   = gnt;
    busy_n  = busy;
    addr_n  = addr;
    sl_n    = 1'b0;
    done_n  = 1'b0;
    clr     = 2'b00;
    win1    = 1'b0;

`ifdef REFRESH_ARB_FIXED_PRIO_EN
    win1 = pend[1];
`else
    // ptr = 1 means source 1 is favoured on a tie.
    win1 = pend[1] & (~pend[0] | ptr);
`endif

    case (state)
      IDLE: begin
        if (|pend) begin
          gnt_n   = win1 ? 2'b10 : 2'b01;
          clr     = gnt_n;
          busy_n  = 1'b1;
          addr_n  = 4'd0;
          hold_n  = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (hold_cnt == HOLD_LAST) begin
          sl_n    = 1'b1;
          state_n = STROBE;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      STROBE: begin
        if (addr == ADDR_LAST) begin
          // Burst ends here; the other source is favoured next time.
          done_n  = 1'b1;
          gnt_n   = 2'b00;
          busy_n  = 1'b0;
          addr_n  = 4'd0;
          ptr_n   = gnt[0];
          state_n = DONE;
        end else begin
          addr_n  = addr + 4'd1;
          hold_n  = '0;
          state_n = SETUP;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A new request beats a same-edge grant clear. A re-request by the source
    // that owns the current burst only re-arms its pending flag.
    pend_n    = req | (pend & ~clr);
    overrun_n = overrun | (req & pend & ~clr & ~gnt);
  end

endmodule
